// File: rtl/bf_loader.sv
// -----------------------------------------------------------------------------
// bf_loader
// Front end of the brainfuck CPU. Takes a raw ASCII brainfuck source stream,
// encodes it into 8-bit instructions and writes them into instruction memory.
// Jump distances for [ ] are resolved with a bracket stack: [ writes an
// unresolved bz stub, and the matching ] writes its bnz and then back-patches
// that stub with the forward distance.
//
// Build option:
//   BF_LOADER_RLE_EN  defined   : runs of + - > < merge into one instruction
//                                 (up to MAX_RUN per instruction)
//                     undefined : every + - > < emits its own instruction, n=1
//
// Ports:
//   clk_in      system clock
//   rst_n       asynchronous active-low reset
//   start       pulse: clear all state and begin a new load
//   char_in     ASCII source character
//   char_valid  char_in valid
//   char_ready  loader accepts char_in this cycle
//   char_last   accepted char is the final one
//   wr_en       instruction write strobe
//   wr_addr     instruction write address
//   wr_data     encoded instruction
//   prog_len    instructions emitted so far
//   busy        load in progress
//   done        load finished cleanly (sticky until start)
//   err         00 none, 01 bracket mismatch, 10 capacity, 11 jump too far
// -----------------------------------------------------------------------------
module bf_loader #(
    parameter int AW          = 5,
    parameter int STACK_DEPTH = 8,
    parameter int MAX_RUN     = 31
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    char_in,
    input  logic          char_valid,
    output logic          char_ready,
    input  logic          char_last,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW:0]   prog_len,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err
);

`ifdef BF_LOADER_RLE_EN
    localparam bit RLE_ON = 1'b1;
`else
    localparam bit RLE_ON = 1'b0;
`endif

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int DW  = AW + 2;

    localparam logic [4:0] MAX_RUN_C = 5'(MAX_RUN);
    localparam logic [7:0] INS_OUT   = 8'h81;
    localparam logic [7:0] INS_IN    = 8'h80;
    localparam logic [7:0] INS_LBR   = 8'hC0;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ACCEPT, ST_FLUSH, ST_WRITE, ST_PATCH, ST_FINISH, ST_DONE, ST_ERROR
    } state_t;

    typedef enum logic [2:0] {
        CL_COMMENT, CL_RUN, CL_IO, CL_LBR, CL_RBR
    } class_t;

    // Work still owed once the current write cycle completes.
    typedef enum logic [2:0] {
        PK_NONE, PK_IO, PK_LBR, PK_RBR, PK_PATCH
    } pend_t;

    function automatic class_t classify(input logic [7:0] c);
        class_t k;
        case (c)
            8'h2B, 8'h2D, 8'h3E, 8'h3C: k = CL_RUN;
            8'h2E, 8'h2C:               k = CL_IO;
            8'h5B:                      k = CL_LBR;
            8'h5D:                      k = CL_RBR;
            default:                    k = CL_COMMENT;
        endcase
        return k;
    endfunction

    function automatic logic [1:0] run_opcode(input logic [7:0] c);
        logic [1:0] op;
        case (c)
            8'h2B:   op = 2'b00;
            8'h2D:   op = 2'b01;
            8'h3E:   op = 2'b10;
            8'h3C:   op = 2'b11;
            default: op = 2'b00;
        endcase
        return op;
    endfunction

    state_t           state_r;
    pend_t            pend_r;
    logic [1:0]       run_op_r;
    logic [4:0]       run_cnt_r;      // 0 means no pending run
    logic [7:0]       io_data_r;
    logic             last_r;
    logic [AW-1:0]    stack_r [STACK_DEPTH];
    logic [SPW-1:0]   sp_r;
    logic [AW-1:0]    patch_addr_r;
    logic [7:0]       patch_data_r;
    logic [AW:0]      prog_len_r;
    logic             wr_en_r;
    logic [AW-1:0]    wr_addr_r;
    logic [7:0]       wr_data_r;
    logic             char_ready_r;
    logic             busy_r;
    logic             done_r;
    logic [1:0]       err_r;

    logic             accept_s;
    class_t           class_s;
    logic [1:0]       op_s;
    logic [7:0]       io_s;
    logic             pending_s;
    logic             same_run_s;
    logic [7:0]       run_data_s;
    logic             stack_empty_s;
    logic             stack_full_s;
    logic [IW-1:0]    top_idx_s;
    logic [AW-1:0]    top_addr_s;
    logic [DW-1:0]    fwd_s;
    logic [DW-1:0]    back_s;
    logic             dist_ok_s;
    logic [7:0]       bnz_data_s;
    logic [7:0]       patch_data_s;
    logic             emit_s;
    logic [7:0]       emit_data_s;

    assign accept_s      = (state_r == ST_ACCEPT) && char_valid && char_ready_r && !start;
    assign class_s       = classify(char_in);
    assign op_s          = run_opcode(char_in);
    assign io_s          = (char_in == 8'h2E) ? INS_OUT : INS_IN;
    assign pending_s     = (run_cnt_r != 5'd0);
    assign same_run_s    = pending_s && (run_op_r == op_s) && (run_cnt_r < MAX_RUN_C);
    assign run_data_s    = {1'b0, run_op_r, run_cnt_r};
    assign stack_empty_s = (sp_r == {SPW{1'b0}});
    assign stack_full_s  = (sp_r == SPW'(STACK_DEPTH));
    assign top_idx_s     = IW'(sp_r - SPW'(1));
    assign top_addr_s    = stack_r[top_idx_s];

    // prog_len is B (the bnz address) at the moment the bnz is written.
    assign fwd_s         = {1'b0, prog_len_r} - DW'(top_addr_s) + DW'(1);
    assign back_s        = fwd_s - DW'(2);
    assign dist_ok_s     = (fwd_s <= DW'(31)) && (back_s <= DW'(31));
    assign bnz_data_s    = {3'b111, back_s[4:0]};
    assign patch_data_s  = {3'b110, fwd_s[4:0]};

    // Sequential instruction write (at address prog_len) requested this cycle.
    always_comb begin
        emit_s      = 1'b0;
        emit_data_s = 8'h00;
        if (start) begin
            emit_s = 1'b0;
        end else if (accept_s) begin
            case (class_s)
                CL_RUN: begin
                    if (!RLE_ON) begin
                        emit_s      = 1'b1;
                        emit_data_s = {1'b0, op_s, 5'd1};
                    end else if (pending_s && !same_run_s) begin
                        emit_s      = 1'b1;
                        emit_data_s = run_data_s;
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                CL_IO: begin
                    emit_s      = 1'b1;
                    emit_data_s = pending_s ? run_data_s : io_s;
                end
                CL_LBR: begin
                    if (!stack_full_s) begin
                        emit_s      = 1'b1;
                        emit_data_s = pending_s ? run_data_s : INS_LBR;
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                CL_RBR: begin
                    if (stack_empty_s) begin
                        emit_s = 1'b0;
                    end else if (pending_s) begin
                        emit_s      = 1'b1;
                        emit_data_s = run_data_s;
                    end else if (dist_ok_s) begin
                        emit_s      = 1'b1;
                        emit_data_s = bnz_data_s;
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                default: emit_s = 1'b0;
            endcase
        end else if (state_r == ST_FLUSH) begin
            case (pend_r)
                PK_IO: begin
                    emit_s      = 1'b1;
                    emit_data_s = io_data_r;
                end
                PK_LBR: begin
                    emit_s      = 1'b1;
                    emit_data_s = INS_LBR;
                end
                PK_RBR: begin
                    if (dist_ok_s) begin
                        emit_s      = 1'b1;
                        emit_data_s = bnz_data_s;
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                default: emit_s = 1'b0;
            endcase
        end else if ((state_r == ST_FINISH) && pending_s) begin
            emit_s      = 1'b1;
            emit_data_s = run_data_s;
        end else begin
            emit_s = 1'b0;
        end
    end

    // Loader FSM: char acceptance, run tracking, bracket stack, writes, status.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pend_r       <= PK_NONE;
            run_op_r     <= 2'b00;
            run_cnt_r    <= 5'd0;
            io_data_r    <= 8'h00;
            last_r       <= 1'b0;
            sp_r         <= {SPW{1'b0}};
            patch_addr_r <= {AW{1'b0}};
            patch_data_r <= 8'h00;
            prog_len_r   <= {(AW+1){1'b0}};
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {AW{1'b0}};
            wr_data_r    <= 8'h00;
            char_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 2'b00;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {AW{1'b0}};
            end
        end else begin
            wr_en_r <= 1'b0;
            if (start) begin
                state_r      <= ST_ACCEPT;
                pend_r       <= PK_NONE;
                run_op_r     <= 2'b00;
                run_cnt_r    <= 5'd0;
                last_r       <= 1'b0;
                sp_r         <= {SPW{1'b0}};
                prog_len_r   <= {(AW+1){1'b0}};
                char_ready_r <= 1'b1;
                busy_r       <= 1'b1;
                done_r       <= 1'b0;
                err_r        <= 2'b00;
            end else begin
                case (state_r)
                    ST_ACCEPT: begin
                        if (accept_s) begin
                            last_r <= char_last;
                            case (class_s)
                                CL_RUN: begin
                                    if (RLE_ON && same_run_s) begin
                                        run_cnt_r    <= run_cnt_r + 5'd1;
                                        state_r      <= char_last ? ST_FINISH : ST_ACCEPT;
                                        char_ready_r <= !char_last;
                                    end else if (pending_s) begin
                                        run_op_r     <= op_s;
                                        run_cnt_r    <= 5'd1;
                                        pend_r       <= PK_NONE;
                                        state_r      <= ST_FLUSH;
                                        char_ready_r <= 1'b0;
                                    end else if (RLE_ON) begin
                                        run_op_r     <= op_s;
                                        run_cnt_r    <= 5'd1;
                                        state_r      <= char_last ? ST_FINISH : ST_ACCEPT;
                                        char_ready_r <= !char_last;
                                    end else begin
                                        pend_r       <= PK_NONE;
                                        state_r      <= ST_WRITE;
                                        char_ready_r <= 1'b0;
                                    end
                                end
                                CL_IO: begin
                                    io_data_r    <= io_s;
                                    char_ready_r <= 1'b0;
                                    if (pending_s) begin
                                        run_cnt_r <= 5'd0;
                                        pend_r    <= PK_IO;
                                        state_r   <= ST_FLUSH;
                                    end else begin
                                        pend_r    <= PK_NONE;
                                        state_r   <= ST_WRITE;
                                    end
                                end
                                CL_LBR: begin
                                    char_ready_r <= 1'b0;
                                    if (stack_full_s) begin
                                        err_r   <= 2'b10;
                                        busy_r  <= 1'b0;
                                        state_r <= ST_ERROR;
                                    end else if (pending_s) begin
                                        run_cnt_r <= 5'd0;
                                        pend_r    <= PK_LBR;
                                        state_r   <= ST_FLUSH;
                                    end else begin
                                        stack_r[sp_r[IW-1:0]] <= prog_len_r[AW-1:0];
                                        sp_r    <= sp_r + SPW'(1);
                                        pend_r  <= PK_NONE;
                                        state_r <= ST_WRITE;
                                    end
                                end
                                CL_RBR: begin
                                    char_ready_r <= 1'b0;
                                    if (stack_empty_s) begin
                                        err_r   <= 2'b01;
                                        busy_r  <= 1'b0;
                                        state_r <= ST_ERROR;
                                    end else if (pending_s) begin
                                        run_cnt_r <= 5'd0;
                                        pend_r    <= PK_RBR;
                                        state_r   <= ST_FLUSH;
                                    end else if (!dist_ok_s) begin
                                        err_r   <= 2'b11;
                                        busy_r  <= 1'b0;
                                        state_r <= ST_ERROR;
                                    end else begin
                                        sp_r         <= sp_r - SPW'(1);
                                        patch_addr_r <= top_addr_s;
                                        patch_data_r <= patch_data_s;
                                        pend_r       <= PK_PATCH;
                                        state_r      <= ST_WRITE;
                                    end
                                end
                                default: begin
                                    state_r      <= char_last ? ST_FINISH : ST_ACCEPT;
                                    char_ready_r <= !char_last;
                                end
                            endcase
                        end
                    end
                    ST_FLUSH: begin
                        case (pend_r)
                            PK_IO: begin
                                pend_r  <= PK_NONE;
                                state_r <= ST_WRITE;
                            end
                            PK_LBR: begin
                                // prog_len already counts the flushed run here
                                stack_r[sp_r[IW-1:0]] <= prog_len_r[AW-1:0];
                                sp_r    <= sp_r + SPW'(1);
                                pend_r  <= PK_NONE;
                                state_r <= ST_WRITE;
                            end
                            PK_RBR: begin
                                if (dist_ok_s) begin
                                    sp_r         <= sp_r - SPW'(1);
                                    patch_addr_r <= top_addr_s;
                                    patch_data_r <= patch_data_s;
                                    pend_r       <= PK_PATCH;
                                    state_r      <= ST_WRITE;
                                end else begin
                                    err_r   <= 2'b11;
                                    busy_r  <= 1'b0;
                                    state_r <= ST_ERROR;
                                end
                            end
                            default: begin
                                state_r      <= last_r ? ST_FINISH : ST_ACCEPT;
                                char_ready_r <= !last_r;
                            end
                        endcase
                    end
                    ST_WRITE: begin
                        if (pend_r == PK_PATCH) begin
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= patch_addr_r;
                            wr_data_r <= patch_data_r;
                            pend_r    <= PK_NONE;
                            state_r   <= ST_PATCH;
                        end else begin
                            state_r      <= last_r ? ST_FINISH : ST_ACCEPT;
                            char_ready_r <= !last_r;
                        end
                    end
                    ST_PATCH: begin
                        state_r      <= last_r ? ST_FINISH : ST_ACCEPT;
                        char_ready_r <= !last_r;
                    end
                    ST_FINISH: begin
                        if (pending_s) begin
                            run_cnt_r <= 5'd0;
                        end else if (!stack_empty_s) begin
                            err_r   <= 2'b01;
                            busy_r  <= 1'b0;
                            state_r <= ST_ERROR;
                        end else begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_DONE;
                        end
                    end
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        state_r <= state_r;
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        char_ready_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                endcase

                // Common write path; a write into a full memory is dropped and
                // overrides whatever transition was chosen above.
                if (emit_s) begin
                    if (prog_len_r[AW]) begin
                        err_r        <= 2'b10;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b0;
                        char_ready_r <= 1'b0;
                        state_r      <= ST_ERROR;
                    end else begin
                        wr_en_r    <= 1'b1;
                        wr_addr_r  <= prog_len_r[AW-1:0];
                        wr_data_r  <= emit_data_s;
                        prog_len_r <= prog_len_r + (AW+1)'(1);
                    end
                end
            end
        end
    end

    assign char_ready = char_ready_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign prog_len   = prog_len_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_bf_loader.sv
// -----------------------------------------------------------------------------
// tb_bf_loader
// Directed bench for bf_loader (AW=5, STACK_DEPTH=8, MAX_RUN=31). Feeds short
// source strings, logs every write strobe and compares against hand-computed
// encodings. Expectations follow the BF_LOADER_RLE_EN build setting.
// -----------------------------------------------------------------------------
module tb_bf_loader;
    localparam int AW = 5;

    logic          clk_in = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    char_in = 8'h00;
    logic          char_valid = 1'b0;
    logic          char_last = 1'b0;
    logic          char_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW:0]   prog_len;
    logic          busy;
    logic          done;
    logic [1:0]    err;

    bf_loader #(.AW(AW), .STACK_DEPTH(8), .MAX_RUN(31)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .start(start),
        .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
        .char_last(char_last), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .prog_len(prog_len), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // write log, sampled on the falling edge
    logic [AW-1:0] log_addr [256];
    logic [7:0]    log_data [256];
    int            nlog = 0;

    always @(negedge clk_in) begin
        if (wr_en === 1'b1 && nlog < 256) begin
            log_addr[nlog] = wr_addr;
            log_data[nlog] = wr_data;
            nlog = nlog + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [AW-1:0] a, input logic [7:0] d);
        check({tag, "_addr"}, 32'(log_addr[idx]), 32'(a));
        check({tag, "_data"}, 32'(log_data[idx]), 32'(d));
    endtask

    task automatic pulse_start();
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic feed(input string s, input bit mark_last, input int max_wait, output bit stalled);
        int w;
        stalled = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            char_in    = s[i];
            char_valid = 1'b1;
            char_last  = mark_last && (i == s.len() - 1);
            w = 0;
            while (char_ready !== 1'b1 && w < max_wait) begin
                @(negedge clk_in);
                w++;
            end
            if (char_ready !== 1'b1) begin
                stalled = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (busy === 1'b1 && w < 500) begin
            @(negedge clk_in);
            w++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  base;
        bit  st;
        int  bad;
        string s40;

        // reset state
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_wr_en",  32'(wr_en),      32'd0);
        check("rst_ready",  32'(char_ready), 32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_done",   32'(done),       32'd0);
        check("rst_err",    32'(err),        32'd0);
        check("rst_len",    32'(prog_len),   32'd0);
        check("rst_wdata",  32'(wr_data),    32'd0);
        rst_n = 1'b1;

        // "+++"
        pulse_start();
        check("st_busy",  32'(busy),       32'd1);
        check("st_ready", 32'(char_ready), 32'd1);
        check("st_len",   32'(prog_len),   32'd0);
        base = nlog;
        feed("+++", 1'b1, 50, st);
        check("t1_stall", 32'(st), 32'd0);
        wait_idle("t1");
`ifdef BF_LOADER_RLE_EN
        check("t1_nwr", 32'(nlog - base), 32'd1);
        check_wr("t1_w0", base, 5'd0, 8'h03);
        check("t1_len", 32'(prog_len), 32'd1);
`else
        check("t1_nwr", 32'(nlog - base), 32'd3);
        check_wr("t1_w0", base,     5'd0, 8'h01);
        check_wr("t1_w1", base + 1, 5'd1, 8'h01);
        check_wr("t1_w2", base + 2, 5'd2, 8'h01);
        check("t1_len", 32'(prog_len), 32'd3);
`endif
        check("t1_done", 32'(done), 32'd1);
        check("t1_err",  32'(err),  32'd0);

        // "+++--"
        pulse_start();
        base = nlog;
        feed("+++--", 1'b1, 50, st);
        check("t2_stall", 32'(st), 32'd0);
        wait_idle("t2");
`ifdef BF_LOADER_RLE_EN
        check("t2_nwr", 32'(nlog - base), 32'd2);
        check_wr("t2_w0", base,     5'd0, 8'h03);
        check_wr("t2_w1", base + 1, 5'd1, 8'h22);
        check("t2_len", 32'(prog_len), 32'd2);
`else
        check("t2_nwr", 32'(nlog - base), 32'd5);
        check_wr("t2_w2", base + 2, 5'd2, 8'h01);
        check_wr("t2_w3", base + 3, 5'd3, 8'h21);
        check_wr("t2_w4", base + 4, 5'd4, 8'h21);
        check("t2_len", 32'(prog_len), 32'd5);
`endif

        // ">x>.<" : the x is a comment and must not break the run
        pulse_start();
        base = nlog;
        feed(">x>.<", 1'b1, 50, st);
        check("t3_stall", 32'(st), 32'd0);
        wait_idle("t3");
`ifdef BF_LOADER_RLE_EN
        check("t3_nwr", 32'(nlog - base), 32'd3);
        check_wr("t3_w0", base,     5'd0, 8'h42);
        check_wr("t3_w1", base + 1, 5'd1, 8'h81);
        check_wr("t3_w2", base + 2, 5'd2, 8'h61);
        check("t3_len", 32'(prog_len), 32'd3);
`else
        check("t3_nwr", 32'(nlog - base), 32'd4);
        check_wr("t3_w0", base,     5'd0, 8'h41);
        check_wr("t3_w1", base + 1, 5'd1, 8'h41);
        check_wr("t3_w2", base + 2, 5'd2, 8'h81);
        check_wr("t3_w3", base + 3, 5'd3, 8'h61);
        check("t3_len", 32'(prog_len), 32'd4);
`endif

        // "[-]" : bz stub, body, bnz, then patch
        pulse_start();
        base = nlog;
        feed("[-]", 1'b1, 50, st);
        check("t4_stall", 32'(st), 32'd0);
        wait_idle("t4");
        check("t4_nwr", 32'(nlog - base), 32'd4);
        check_wr("t4_w0", base,     5'd0, 8'hC0);
        check_wr("t4_w1", base + 1, 5'd1, 8'h21);
        check_wr("t4_w2", base + 2, 5'd2, 8'hE1);
        check_wr("t4_pa", base + 3, 5'd0, 8'hC3);
        check("t4_len",  32'(prog_len), 32'd3);
        check("t4_done", 32'(done),     32'd1);
        check("t4_err",  32'(err),      32'd0);

        // "]" with empty stack
        pulse_start();
        base = nlog;
        feed("]", 1'b1, 50, st);
        wait_idle("t5");
        check("t5_err",  32'(err),          32'd1);
        check("t5_done", 32'(done),         32'd0);
        check("t5_nwr",  32'(nlog - base),  32'd0);

        // "[[" : unmatched at finish
        pulse_start();
        base = nlog;
        feed("[[", 1'b1, 50, st);
        wait_idle("t6");
        check("t6_err",  32'(err),         32'd1);
        check("t6_nwr",  32'(nlog - base), 32'd2);
        check_wr("t6_w1", base + 1, 5'd1, 8'hC0);

        // nine nested [ : stack overflow on the ninth
        pulse_start();
        base = nlog;
        feed("[[[[[[[[[", 1'b0, 50, st);
        wait_idle("t7");
        check("t7_err",  32'(err),         32'd2);
        check("t7_nwr",  32'(nlog - base), 32'd8);
        check("t7_len",  32'(prog_len),    32'd8);

        // 40 x '+'
        s40 = "";
        for (int i = 0; i < 40; i++) s40 = {s40, "+"};
        pulse_start();
        base = nlog;
        feed(s40, 1'b1, 20, st);
        wait_idle("t8");
`ifdef BF_LOADER_RLE_EN
        check("t8_nwr", 32'(nlog - base), 32'd2);
        check_wr("t8_w0", base,     5'd0, 8'h1F);
        check_wr("t8_w1", base + 1, 5'd1, 8'h09);
        check("t8_err",  32'(err),  32'd0);
        check("t8_done", 32'(done), 32'd1);
`else
        check("t8_nwr", 32'(nlog - base), 32'd32);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (log_data[base + i] !== 8'h01 || log_addr[base + i] !== 5'(i)) bad++;
        end
        check("t8_data", 32'(bad), 32'd0);
        check("t8_err",  32'(err),      32'd2);
        check("t8_len",  32'(prog_len), 32'd32);
        check("t8_done", 32'(done),     32'd0);
`endif

        // asynchronous reset in the middle of a stream, char_valid held
        pulse_start();
        char_in    = 8'h2B;
        char_valid = 1'b1;
        char_last  = 1'b0;
        repeat (5) @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        check("t9_wr_en", 32'(wr_en),      32'd0);
        check("t9_busy",  32'(busy),       32'd0);
        check("t9_ready", 32'(char_ready), 32'd0);
        check("t9_len",   32'(prog_len),   32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        check("t9_idle_ready", 32'(char_ready), 32'd0);
        char_valid = 1'b0;
        pulse_start();
        base = nlog;
        feed(".", 1'b1, 50, st);
        check("t9_stall", 32'(st), 32'd0);
        wait_idle("t9");
        check("t9_nwr", 32'(nlog - base), 32'd1);
        check_wr("t9_w0", base, 5'd0, 8'h81);
        check("t9_done", 32'(done),     32'd1);
        check("t9_plen", 32'(prog_len), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
